sc_bs_decoder: RTL and testbench
================================

Name: sc_bs_decoder

Overview:
Stochastic-to-binary decoder. It reads the unipolar bitstream produced by the divide/square-root stream units (and other SC blocks) and counts the ones over a fixed frame of 2^BITW accepted bits. It then delivers the count as a binary value through a valid/ready output port. It is the reader end of the SC datapath, used for result capture and on-chip accuracy checks.

Parameters:
BITW, 8, log2 of frame length; N = 2^BITW accepted bits per frame
CONT, 0, 1 = frames run back-to-back after start; 0 = one frame per start

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
start  input  1  begin a frame (or a continuous run when CONT=1); sampled only in IDLE
stop  input  1  abort: discard the partial frame and return to IDLE
in_valid  input  1  the in bit is valid this cycle
in  input  1  bitstream bit
out_valid  output  1  result held in output register
out_ready  input  1  consumer accepts result
out_value  output  BITW+1  ones count of the frame, 0..N
busy  output  1  high in ACC state
overrun  output  1  one-cycle pulse: an unconsumed result was overwritten

Behaviour:
- Reset (rst=1 at posedge): state IDLE; acc=0, cnt=0; out_valid=0, out_value=0, busy=0, overrun=0. Reset applies even mid-frame; the partial count is lost.
- State IDLE:
  - start=1 -> ACC next cycle; acc=0, cnt=0.
  - in/in_valid are ignored in IDLE.
- State ACC (busy=1): each cycle with in_valid=1:
  - acc += in;
  - cnt += 1 (width BITW, wraps N-1 -> 0).
  - in_valid=0 leaves acc and cnt unchanged.
- Frame end: the cycle with in_valid=1 and cnt==N-1.
  - Result register loads acc+in; out_valid=1 from the next cycle. Latency = 1 cycle after the last accepted bit.
  - acc and cnt clear in the same cycle.
  - CONT=0: go to IDLE.
  - CONT=1: stay in ACC; the next cycle's valid bit is bit 0 of the next frame. No gap cycles.
- Output handshake:
  - Transfer occurs on any cycle with out_valid=1 and out_ready=1.
  - out_value is stable while out_valid=1 and not transferred.
  - Transfer with no new result -> out_valid=0 next cycle; out_value retains its last value.
- Simultaneous transfer and frame end: the old result transfers, the new result loads, out_valid stays 1, no overrun.
- Frame end while out_valid=1 and out_ready=0: the new result overwrites the old one, out_valid stays 1, overrun=1 for exactly one cycle. This case is only reachable when CONT=1, or when start is re-issued before consumption.
- stop=1:
  - in ACC: go to IDLE next cycle; acc and cnt cleared; the output register is untouched.
  - stop has priority over a frame end in the same cycle; that frame is discarded.
  - stop in IDLE has no effect.
  - stop and start together in IDLE: stop wins, stay IDLE.
- start while in ACC is ignored.
- Width: acc is BITW+1 bits and cannot exceed N, so there is no saturation.

Test Plan:
- BITW=4, CONT=0: start, then 16 valid bits all 1 -> out_value=16, out_valid rises 1 cycle after the 16th bit, state IDLE, busy=0.
- BITW=4: pattern 1010… over 16 valid bits, with in_valid deasserted on 5 random cycles (in=1 on those cycles) -> out_value=8; gapped cycles are not counted.
- BITW=4, CONT=1, out_ready=1 constantly: 3 frames of 4/16, 0/16 and 12/16 ones -> out_value sequence 4, 0, 12; out_valid pulses one cycle each; no overrun.
- BITW=4, CONT=1, out_ready=0: two frames (5, then 9 ones) -> out_value=9, overrun pulses once at the second load, out_valid stays 1; raising out_ready drops out_valid the next cycle.
- stop asserted at bit 10 of a frame, and separately in the same cycle as bit 16 -> no result in either case, out_valid stays 0, state IDLE; a new start gives a clean count.
- rst asserted at bit 7 of a frame -> all outputs 0 on the next cycle; start after reset with 16 zeros -> out_value=0.

Source files
------------

// File: rtl/sc_bs_decoder.sv
// sc_bs_decoder: counts ones over a 2^BITW-bit frame of a unipolar stochastic stream and hands the count out via valid/ready
module sc_bs_decoder #(
  parameter int BITW = 8,
  parameter bit CONT = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            stop,
  input  logic            in_valid,
  input  logic            in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITW:0]   out_value,
  output logic            busy,
  output logic            overrun
);
  typedef enum logic {IDLE, ACC} state_t;
  state_t          state_q;
  logic [BITW:0]   acc_q, sum_d, out_value_q;
  logic [BITW-1:0] cnt_q;
  logic            out_valid_q, overrun_q, frame_end_d;
  // running sum including this cycle's bit, and whether this bit closes the frame (stop discards it)
  always_comb begin
    sum_d = acc_q + {{BITW{1'b0}}, in};
    frame_end_d = state_q == ACC && !stop && in_valid && &cnt_q;
  end
  // frame accumulator FSM plus the output result register and its handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q <= '0;
      cnt_q <= '0;
      out_valid_q <= 1'b0;
      out_value_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= frame_end_d && out_valid_q && !out_ready;
      if (frame_end_d) begin
        out_value_q <= sum_d;
        out_valid_q <= 1'b1;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
      case (state_q)
        IDLE: if (start && !stop) begin
          state_q <= ACC;
          acc_q <= '0;
          cnt_q <= '0;
        end
        ACC: if (stop) begin
          state_q <= IDLE;
          acc_q <= '0;
          cnt_q <= '0;
        end else if (in_valid) begin
          if (&cnt_q) begin
            acc_q <= '0;
            cnt_q <= '0;
            if (!CONT) state_q <= IDLE;
          end else begin
            acc_q <= sum_d;
            cnt_q <= cnt_q + {{(BITW-1){1'b0}}, 1'b1};
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign out_valid = out_valid_q;
  assign out_value = out_value_q;
  assign overrun = overrun_q;
  assign busy = state_q == ACC;
endmodule

// File: tb/tb_sc_bs_decoder.sv
// tb_sc_bs_decoder: single-frame and continuous decoders driven in parallel, checked against a frame-queue model
module tb_sc_bs_decoder;
  localparam int BITW = 4;
  localparam int N = 1 << BITW;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0, in_valid = 1'b0, in = 1'b0, out_ready = 1'b1;
  logic [1:0] ov, bz, ovr;
  logic [BITW:0] val [2];
  int checks = 0, errors = 0;
  bit armed = 1'b0;
  bit m_run [2], m_ov [2], m_ovr [2];
  int m_val [2];
  int mq [2][$];

  sc_bs_decoder #(.BITW(BITW), .CONT(1'b0)) u0 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .in_valid(in_valid), .in(in),
    .out_valid(ov[0]), .out_ready(out_ready), .out_value(val[0]), .busy(bz[0]), .overrun(ovr[0]));
  sc_bs_decoder #(.BITW(BITW), .CONT(1'b1)) u1 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .in_valid(in_valid), .in(in),
    .out_valid(ov[1]), .out_ready(out_ready), .out_value(val[1]), .busy(bz[1]), .overrun(ovr[1]));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int k, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s[%0d] got %0d expected %0d at %0t", nm, k, act, exp_v, $time);
    end
  endtask

  // model: a frame is the list of accepted bits; when it holds N bits its sum is the result
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      bit done;
      int s;
      done = 1'b0;
      s = 0;
      if (rst) begin
        m_run[k] = 1'b0;
        mq[k].delete();
        m_ov[k] = 1'b0;
        m_val[k] = 0;
        m_ovr[k] = 1'b0;
      end else begin
        if (m_run[k]) begin
          if (stop) begin
            m_run[k] = 1'b0;
            mq[k].delete();
          end else if (in_valid) begin
            mq[k].push_back(int'(in));
            if (mq[k].size() == N) begin
              foreach (mq[k][j]) s += mq[k][j];
              mq[k].delete();
              done = 1'b1;
              if (k == 0) m_run[k] = 1'b0;
            end
          end
        end else if (start && !stop) begin
          m_run[k] = 1'b1;
          mq[k].delete();
        end
        m_ovr[k] = done && m_ov[k] && !out_ready;
        if (done) begin
          m_val[k] = s;
          m_ov[k] = 1'b1;
        end else if (out_ready) m_ov[k] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      for (int k = 0; k < 2; k++) begin
        chk("out_valid", k, int'(ov[k]), int'(m_ov[k]));
        chk("out_value", k, int'(val[k]), m_val[k]);
        chk("busy", k, int'(bz[k]), int'(m_run[k]));
        chk("overrun", k, int'(ovr[k]), int'(m_ovr[k]));
      end
    end
  end

  task automatic cyc(input logic s, input logic p, input logic v, input logic b);
    start = s;
    stop = p;
    in_valid = v;
    in = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    armed = 1'b1;
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk("rst_value", k, int'(val[k]), 0);
      chk("rst_valid", k, int'(ov[k]), 0);
      chk("rst_busy", k, int'(bz[k]), 0);
    end
    // all ones
    cyc(1, 0, 0, 0);
    for (int i = 0; i < N; i++) cyc(0, 0, 1, 1);
    chk("ones_value", 0, int'(val[0]), 16);
    chk("ones_valid", 0, int'(ov[0]), 1);
    chk("ones_busy", 0, int'(bz[0]), 0);
    chk("ones_busy", 1, int'(bz[1]), 1);
    cyc(0, 1, 0, 0);
    // alternating pattern with gaps carrying in=1
    cyc(1, 0, 0, 0);
    for (int i = 0; i < N; i++) begin
      if (i == 2 || i == 5 || i == 7 || i == 11 || i == 13) cyc(0, 0, 0, 1);
      cyc(0, 0, 1, logic'(i % 2 == 0));
    end
    chk("gap_value", 0, int'(val[0]), 8);
    chk("gap_value", 1, int'(val[1]), 8);
    cyc(0, 1, 0, 0);
    // continuous frames 4, 0, 12 with ready held high
    cyc(1, 0, 0, 0);
    for (int i = 0; i < N; i++) cyc(0, 0, 1, logic'(i < 4));
    chk("cont_f1", 1, int'(val[1]), 4);
    chk("cont_f1", 0, int'(val[0]), 4);
    cyc(0, 0, 1, 0);
    chk("cont_pulse", 1, int'(ov[1]), 0);
    for (int i = 1; i < N; i++) cyc(0, 0, 1, 0);
    chk("cont_f2", 1, int'(val[1]), 0);
    chk("cont_f2_valid", 1, int'(ov[1]), 1);
    for (int i = 0; i < N; i++) cyc(0, 0, 1, logic'(i < 12));
    chk("cont_f3", 1, int'(val[1]), 12);
    chk("cont_ovr", 1, int'(ovr[1]), 0);
    cyc(0, 1, 0, 0);
    // continuous frames 5, 9 with ready low
    out_ready = 1'b0;
    cyc(1, 0, 0, 0);
    for (int i = 0; i < N; i++) cyc(0, 0, 1, logic'(i < 5));
    for (int i = 0; i < N; i++) cyc(0, 0, 1, logic'(i < 9));
    chk("ovr_value", 1, int'(val[1]), 9);
    chk("ovr_pulse", 1, int'(ovr[1]), 1);
    chk("ovr_valid", 1, int'(ov[1]), 1);
    chk("ovr_value", 0, int'(val[0]), 5);
    cyc(0, 1, 0, 0);
    chk("ovr_pulse_end", 1, int'(ovr[1]), 0);
    chk("ovr_hold", 1, int'(ov[1]), 1);
    out_ready = 1'b1;
    cyc(0, 0, 0, 0);
    chk("ready_drop", 1, int'(ov[1]), 0);
    chk("ready_drop", 0, int'(ov[0]), 0);
    // stop at bit 10, then stop together with bit 16
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 9; i++) cyc(0, 0, 1, 1);
    cyc(0, 1, 1, 1);
    chk("stop10_busy", 0, int'(bz[0]), 0);
    chk("stop10_valid", 1, int'(ov[1]), 0);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < N - 1; i++) cyc(0, 0, 1, 1);
    cyc(0, 1, 1, 1);
    chk("stop16_valid", 0, int'(ov[0]), 0);
    chk("stop16_busy", 1, int'(bz[1]), 0);
    cyc(1, 1, 0, 0);
    chk("stop_start", 0, int'(bz[0]), 0);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < N; i++) cyc(0, 0, 1, logic'(i < 3));
    chk("clean_value", 0, int'(val[0]), 3);
    cyc(0, 1, 0, 0);
    // reset mid-frame
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 1, 1);
    rst = 1'b1;
    cyc(0, 0, 1, 1);
    rst = 1'b0;
    chk("midrst_value", 0, int'(val[0]), 0);
    chk("midrst_busy", 1, int'(bz[1]), 0);
    chk("midrst_valid", 1, int'(ov[1]), 0);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < N; i++) cyc(0, 0, 1, 0);
    chk("zeros_value", 0, int'(val[0]), 0);
    chk("zeros_valid", 0, int'(ov[0]), 1);
    repeat (2) cyc(0, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
